// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the control FSM state encoding and the default parameter values
// used by mem_arbiter and streak_counter.
package mem_arbiter_pkg;

    localparam int AW_DEF         = 16;
    localparam int DW_DEF         = 16;
    localparam int STREAK_MAX_DEF = 4;

    // IDLE/RESP_* are the arbitration states; ACC_* drive the memory.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACC_CPU  = 3'd1,
        ACC_DMA  = 3'd2,
        RESP_CPU = 3'd3,
        RESP_DMA = 3'd4
    } state_t;

endpackage

// File: rtl/mem_arbiter_streak_counter.sv
// streak_counter: counts consecutive CPU wins while a DMA request waits.
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   dma_req      DMA request level; low clears the count every cycle
//   cpu_win      CPU won arbitration this cycle
//   dma_win      DMA won arbitration this cycle (clears the count)
//   at_max       count has saturated at STREAK_MAX (DMA must win next)
module streak_counter
    import mem_arbiter_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic CLK,
    input  logic Reset,
    input  logic dma_req,
    input  logic cpu_win,
    input  logic dma_win,
    output logic at_max
);

    localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] MAXV = SW'(STREAK_MAX);

    logic [SW-1:0] streak;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            streak <= '0;
        end else if (!dma_req || dma_win) begin
            streak <= '0;
        end else if (cpu_win && streak != MAXV) begin
            streak <= streak + 1'b1;
        end
    end

    assign at_max = (streak == MAXV);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU, DMA) arbiter in front of a single memory.
// Each access takes two cycles: ACC (strobe memory) then RESP (done pulse,
// read data returned). Arbitration happens in IDLE and in both RESP states,
// so back-to-back traffic sustains one access every two cycles. The CPU has
// priority, but after STREAK_MAX consecutive CPU wins with DMA waiting, DMA
// is forced to win.
// Ports:
//   CLK, Reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request (held until cpu_done)
//   cpu_gnt, cpu_done, cpu_rdata     CPU grant, completion pulse, read data
//   dma_*                            same set for the DMA/loader port
//   mem_en/we/addr/wdata, mem_rdata  memory side; rdata valid one cycle
//                                    after a mem_en read
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state, state_nxt;
    logic          arb, at_max, cpu_win, dma_win;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rd_q, dma_rd_q;
    logic          cpu_rd_cmp, dma_rd_cmp;

    assign arb     = (state == IDLE) || (state == RESP_CPU) || (state == RESP_DMA);
    assign cpu_win = arb && cpu_req && !(dma_req && at_max);
    assign dma_win = arb && dma_req && !cpu_win;

    streak_counter #(.STREAK_MAX(STREAK_MAX)) u_streak (
        .CLK     (CLK),
        .Reset   (Reset),
        .dma_req (dma_req),
        .cpu_win (cpu_win),
        .dma_win (dma_win),
        .at_max  (at_max)
    );

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        cpu_done  = 1'b0;
        dma_done  = 1'b0;
        mem_en    = 1'b0;
        case (state)
            ACC_CPU: begin
                cpu_gnt   = 1'b1;
                mem_en    = 1'b1;
                state_nxt = RESP_CPU;
            end
            ACC_DMA: begin
                dma_gnt   = 1'b1;
                mem_en    = 1'b1;
                state_nxt = RESP_DMA;
            end
            default: begin
                cpu_done = (state == RESP_CPU);
                dma_done = (state == RESP_DMA);
                if (cpu_win)      state_nxt = ACC_CPU;
                else if (dma_win) state_nxt = ACC_DMA;
            end
        endcase
    end

    // Request fields are captured on the win so the requester may change
    // them once the access is in flight.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cpu_win) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end else if (dma_win) begin
            we_q    <= dma_we;
            addr_q  <= dma_addr;
            wdata_q <= dma_wdata;
        end
    end

    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // mem_rdata only arrives in the RESP cycle, so the done cycle forwards it
    // straight through while the holding register captures it for later.
    assign cpu_rd_cmp = (state == RESP_CPU) && !we_q;
    assign dma_rd_cmp = (state == RESP_DMA) && !we_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
        end else begin
            if (cpu_rd_cmp) cpu_rd_q <= mem_rdata;
            if (dma_rd_cmp) dma_rd_q <= mem_rdata;
        end
    end

    assign cpu_rdata = cpu_rd_cmp ? mem_rdata : cpu_rd_q;
    assign dma_rdata = dma_rd_cmp ? mem_rdata : dma_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        CLK, Reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_done;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.AW(16), .DW(16), .STREAK_MAX(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous memory: read data appears one cycle after the mem_en read.
    logic [15:0] mem [0:1023];
    always @(posedge CLK) begin
        if (Reset) mem[10'h010] <= 16'h1234;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    // data = write data for writes, expected read data for reads
    typedef struct {
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t        sb[$];
    logic [15:0] last_rd [2];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        acc_t e;
        int   p;
        chk("one_gnt", 32'(cpu_gnt & dma_gnt), 32'd0);
        chk("one_done", 32'(cpu_done & dma_done), 32'd0);
        if (cpu_gnt || dma_gnt) begin
            chk("gnt_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("gnt_port", 32'(dma_gnt), 32'(e.dma));
                chk("mem_en", 32'(mem_en), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(e.we));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end
        end else begin
            chk("mem_en_idle", 32'(mem_en), 32'd0);
        end
        if (cpu_done || dma_done) begin
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                p = e.dma ? 1 : 0;
                chk("done_port", 32'(dma_done), 32'(e.dma));
                if (!e.we) last_rd[p] = e.data;
                chk("rdata", 32'(e.dma ? dma_rdata : cpu_rdata), 32'(last_rd[p]));
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit dma, input bit req, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (dma) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic push(input bit dma, input bit we, input logic [15:0] addr,
                        input logic [15:0] data);
        acc_t e;
        e.dma = dma; e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    // Single access from idle; checks gnt at N+1 and a one-cycle done at N+2.
    task automatic do_access(input bit dma, input bit we, input logic [15:0] addr,
                             input logic [15:0] data, input bit bump_addr);
        push(dma, we, addr, data);
        drive(dma, 1'b1, we, addr, we ? data : 16'h0000);
        chk("pre_gnt", 32'(cpu_gnt | dma_gnt), 32'd0);
        tick();
        chk("gnt_lat", 32'(dma ? dma_gnt : cpu_gnt), 32'd1);
        if (bump_addr) begin
            if (dma) dma_addr = addr + 16'h0010;
            else     cpu_addr = addr + 16'h0010;
        end
        tick();
        drive(dma, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("done_lat", 32'(dma ? dma_done : cpu_done), 32'd1);
        chk("other_done", 32'(dma ? cpu_done : dma_done), 32'd0);
        tick();
        chk("done_pulse", 32'(dma ? dma_done : cpu_done), 32'd0);
    endtask

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge CLK); #1;
        tick();
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dma_done", 32'(dma_done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        Reset = 1'b0;

        // CPU read, address changed after the latch cycle
        do_access(1'b0, 1'b0, 16'h0010, 16'h1234, 1'b1);
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'h1234);

        // DMA write with CPU idle
        do_access(1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0);
        chk("cpu_rdata_after_dma", 32'(cpu_rdata), 32'h1234);

        // CPU write leaves cpu_rdata alone, then read it back
        do_access(1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0);
        chk("cpu_rdata_after_wr", 32'(cpu_rdata), 32'h1234);
        do_access(1'b0, 1'b0, 16'h0020, 16'h5555, 1'b0);

        // Simultaneous requests from idle: CPU first, DMA right after
        push(1'b0, 1'b0, 16'h0010, 16'h1234);
        push(1'b1, 1'b0, 16'h0200, 16'hBEEF);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        tick();
        chk("both_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("both_cpu_done", 32'(cpu_done), 32'd1);
        tick();
        chk("both_dma_gnt", 32'(dma_gnt), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("both_dma_done", 32'(dma_done), 32'd1);
        tick();

        // Both held: CPU x4, DMA, repeated
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) push(1'b0, 1'b0, 16'h0010, 16'h1234);
            push(1'b1, 1'b0, 16'h0200, 16'hBEEF);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        for (int k = 0; k < 20; k++) tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("fair_last_done", 32'(dma_done), 32'd1);
        tick();
        chk("fair_all_done", 32'(sb.size()), 32'd0);
        sb.delete();

        // Reset during ACC_DMA aborts the access
        push(1'b1, 1'b0, 16'h0200, 16'hBEEF);
        drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        tick();
        chk("abort_gnt", 32'(dma_gnt), 32'd1);
        Reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        Reset = 1'b0;
        sb.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_no_done", 32'(dma_done), 32'd0);
        chk("abort_dma_rdata", 32'(dma_rdata), 32'd0);
        tick();
        chk("abort_no_done2", 32'(dma_done), 32'd0);
        do_access(1'b0, 1'b0, 16'h0010, 16'h1234, 1'b0);
        chk("post_abort_rdata", 32'(cpu_rdata), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, memory address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 Parameter STREAK_MAX, default 4, maximum consecutive CPU grants while a DMA request waits.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 cpu_req  input  1  CPU (control/datapath) access request, level.
REQ-007 cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-008 cpu_addr  input  AW  CPU address (PC or ALUOut per IorD).
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_gnt  output  1  CPU access issued this cycle.
REQ-011 cpu_done  output  1  one-cycle pulse; CPU access complete, cpu_rdata valid for reads.
REQ-012 cpu_rdata  output  DW  CPU read data.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: the same as REQ-006..012, for the DMA/loader port.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_we  output  1  memory write strobe, valid only with mem_en.
REQ-016 mem_addr  output  AW  memory address.
REQ-017 mem_wdata  output  DW  memory write data.
REQ-018 mem_rdata  input  DW  memory read data, valid exactly one cycle after a mem_en read.

Function
REQ-019 The FSM SHALL have states IDLE, ACC_CPU, ACC_DMA, RESP_CPU and RESP_DMA.
REQ-020 Arbitration SHALL occur in IDLE, RESP_CPU and RESP_DMA; the winner's we/addr/wdata are latched and the next state is ACC_<winner>; with no request pending, the next state is IDLE.
REQ-021 Winner rule: CPU if cpu_req, except that DMA wins when dma_req and streak == STREAK_MAX; DMA if only dma_req.
REQ-022 streak SHALL increment (saturating at STREAK_MAX) on each CPU win while dma_req=1, and clear on a DMA win or whenever dma_req=0.
REQ-023 In ACC_x: gnt_x=1, mem_en=1, mem_we/mem_addr/mem_wdata = latched values; next state RESP_x unconditionally.
REQ-024 In RESP_x: done_x=1 for exactly one cycle and rdata_x = mem_rdata (reads); for writes, rdata_x is unchanged and done_x still pulses.
REQ-025 Latency: request sampled in cycle N -> gnt in N+1 -> done in N+2; back-to-back sustained throughput is one access per 2 cycles.
REQ-026 Requesters SHALL hold req/we/addr/wdata stable until done; changes after the latch cycle SHALL NOT affect the access in flight.
REQ-027 req still high in the done cycle SHALL count as a new request and SHALL be arbitrated in that same cycle.
REQ-028 rdata_x SHALL be registered and SHALL hold its value until the next read completion on that port.
REQ-029 At most one of cpu_gnt/dma_gnt and at most one of cpu_done/dma_done SHALL be high in any cycle; mem_en=0 in IDLE and RESP states.

Reset
REQ-030 Reset SHALL force state=IDLE, streak=0, all gnt/done/mem_en/mem_we=0, latched addr/wdata=0 and rdata=0.
REQ-031 Reset asserted during ACC_x or RESP_x SHALL abort the access: no done pulse afterwards, and no mem_en in the cycle following the reset edge.
REQ-032 The first arbitration after reset SHALL occur in the first cycle with Reset=0.

Structure
REQ-033 The state encoding and the default parameter constants SHALL live in the shared package used by the control FSM.
REQ-034 The starvation counter (REQ-022) SHALL be one sub-module, streak_counter; all other logic stays in mem_arbiter.

Verification
REQ-035 Single CPU read of addr 0x0010, memory returning 0x1234: cpu_gnt at N+1, mem_en=1 with mem_addr=0x0010, cpu_done at N+2 with cpu_rdata=0x1234.
REQ-036 DMA write of 0xBEEF to 0x0200 with CPU idle: mem_we=1, mem_wdata=0xBEEF at N+1, dma_done at N+2, cpu_* outputs silent.
REQ-037 cpu_req and dma_req held high continuously, STREAK_MAX=4: grant order CPU,CPU,CPU,CPU,DMA repeating, with no DMA wait exceeding 4 CPU accesses.
REQ-038 Both requests arrive in the same IDLE cycle with streak=0: CPU wins; DMA is granted immediately after the CPU's RESP if cpu_req drops.
REQ-039 Reset pulsed in an ACC_DMA cycle: no dma_done, next cycle mem_en=0, and state is IDLE; a following CPU request completes normally in 2 cycles.
REQ-040 cpu_addr changed from 0x0010 to 0x0020 after the latch cycle: mem_addr stays 0x0010 for the access in flight.
